// File: rtl/dit_fft_stream.sv
// dit_fft_stream: streaming radix-2 decimation-in-time FFT, one frame at a time.
// A frame of N complex samples is loaded in bit-reversed order, transformed in
// place with one butterfly per cycle, then unloaded bin by bin in natural order.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   in_valid/in_ready   input sample handshake (ready only while loading)
//   in_re, in_im        signed DW-bit input sample
//   out_valid/out_ready output bin handshake (valid only while unloading)
//   out_re, out_im      signed OW-bit bin value, zero when out_valid is low
//   out_idx             index of the bin currently presented
//   busy                high while butterflies are being computed
module dit_fft_stream #(
    parameter int DW    = 8,
    parameter int LOG2N = 3,
    parameter int TWW   = 8,
    localparam int OW   = DW + LOG2N + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im,
    output logic [LOG2N-1:0]     out_idx,
    output logic                 busy
);

    localparam int N     = 1 << LOG2N;
    localparam int HALF  = N / 2;
    localparam int PW    = OW + TWW + 1;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        UNLOAD
    } state_t;

    // cos(2*pi*m/16) for m = 0..4 in Q16; every twiddle of N = 4, 8 or 16 maps
    // onto one of the eight 16-point angles, so this quarter wave covers them all.
    function automatic logic [16:0] cosQ16(input int idx);
        case (idx)
            0:       return 17'd65536;
            1:       return 17'd60547;
            2:       return 17'd46341;
            3:       return 17'd25080;
            default: return 17'd0;
        endcase
    endfunction

    // round(mag * S) with S = 2^(TWW-2), applied to the magnitude so that
    // negative entries round symmetrically with positive ones.
    function automatic logic [TWW-1:0] scaleQ16(input logic [16:0] mag, input logic neg);
        logic [47:0]    t;
        logic [TWW-1:0] r;
        t = ({31'd0, mag} << (TWW - 2)) + 48'd32768;
        t = t >> 16;
        r = t[TWW-1:0];
        return neg ? -r : r;
    endfunction

    // Eight-entry table indexed by the 16-point angle m: real part cos, imaginary
    // part -sin (W = cos - j sin). sin is read from the cosine table shifted by 90 deg.
    function automatic logic [8*TWW-1:0] buildTwiddle(input logic wantIm);
        logic [8*TWW-1:0] tbl;
        tbl = '0;
        for (int m = 0; m < 8; m++) begin
            if (!wantIm) begin
                if (m <= 4) tbl[m*TWW +: TWW] = scaleQ16(cosQ16(m), 1'b0);
                else        tbl[m*TWW +: TWW] = scaleQ16(cosQ16(8 - m), 1'b1);
            end else begin
                if (m <= 4) tbl[m*TWW +: TWW] = scaleQ16(cosQ16(4 - m), 1'b1);
                else        tbl[m*TWW +: TWW] = scaleQ16(cosQ16(m - 4), 1'b1);
            end
        end
        return tbl;
    endfunction

    localparam logic [8*TWW-1:0] TW_RE_TBL = buildTwiddle(1'b0);
    localparam logic [8*TWW-1:0] TW_IM_TBL = buildTwiddle(1'b1);

    function automatic logic [LOG2N-1:0] bitRev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [LOG2N-1:0]     cnt_q, cnt_d;
    logic [LOG2N-1:0]     idx_q, idx_d;
    logic [1:0]           stage_q, stage_d;
    logic [LOG2N-2:0]     bfly_q, bfly_d;

    logic signed [OW-1:0] memRe_q [N];
    logic signed [OW-1:0] memIm_q [N];

    logic                 wrLoad;
    logic                 wrBfly;

    logic [LOG2N-1:0]     spanBit;
    logic [LOG2N-1:0]     posMask;
    logic [LOG2N-1:0]     jIdx;
    logic [LOG2N-1:0]     pos;
    logic [LOG2N-1:0]     aAddr;
    logic [LOG2N-1:0]     bAddr;
    logic [2:0]           twShift;
    logic [2:0]           m16;

    logic signed [OW-1:0]  aRe, aIm, bRe, bIm;
    logic signed [TWW-1:0] wRe, wIm;
    logic signed [PW-1:0]  prodRe, prodIm;
    logic signed [OW-1:0]  pRe, pIm;
    logic signed [OW-1:0]  sumRe, sumIm, difRe, difIm;

    // Butterfly j of stage s pairs addresses a and a + 2^s, where a keeps the
    // low s bits of j and shifts the upper bits up by one to skip the partner half.
    // The twiddle index (j mod 2^s) * 2^(LOG2N-1-s) is rescaled onto the
    // 16-point table by a further shift of 4-LOG2N.
    always_comb begin
        spanBit = LOG2N'(1) << stage_q;
        posMask = spanBit - LOG2N'(1);
        jIdx    = {1'b0, bfly_q};
        pos     = jIdx & posMask;
        aAddr   = ((jIdx & ~posMask) << 1) | pos;
        bAddr   = aAddr | spanBit;
        twShift = 3'(LOG2N - 1) - 3'(stage_q);
        m16     = 3'((4'(pos) << twShift) << (4 - LOG2N));
    end

    // Complex multiply at full precision, floor-shift back to sample scale,
    // then the add/subtract that wraps at OW bits.
    always_comb begin
        aRe    = memRe_q[aAddr];
        aIm    = memIm_q[aAddr];
        bRe    = memRe_q[bAddr];
        bIm    = memIm_q[bAddr];
        wRe    = TW_RE_TBL[int'(m16)*TWW +: TWW];
        wIm    = TW_IM_TBL[int'(m16)*TWW +: TWW];
        prodRe = PW'(bRe) * PW'(wRe) - PW'(bIm) * PW'(wIm);
        prodIm = PW'(bRe) * PW'(wIm) + PW'(bIm) * PW'(wRe);
        pRe    = OW'(prodRe >>> (TWW - 2));
        pIm    = OW'(prodIm >>> (TWW - 2));
        sumRe  = aRe + pRe;
        sumIm  = aIm + pIm;
        difRe  = aRe - pRe;
        difIm  = aIm - pIm;
    end

    // Control state and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        stage_d   = stage_q;
        bfly_d    = bfly_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        wrLoad    = 1'b0;
        wrBfly    = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wrLoad = 1'b1;
                    cnt_d  = cnt_q + LOG2N'(1);
                    if (cnt_q == LOG2N'(N - 1)) begin
                        state_d = COMPUTE;
                        stage_d = '0;
                        bfly_d  = '0;
                    end
                end
            end
            COMPUTE: begin
                busy   = 1'b1;
                wrBfly = 1'b1;
                if (bfly_q == (LOG2N-1)'(HALF - 1)) begin
                    bfly_d = '0;
                    if (stage_q == 2'(LOG2N - 1)) begin
                        state_d = UNLOAD;
                        stage_d = '0;
                        idx_d   = '0;
                    end else begin
                        stage_d = stage_q + 2'd1;
                    end
                end else begin
                    bfly_d = bfly_q + (LOG2N-1)'(1);
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    idx_d = idx_q + LOG2N'(1);
                    if (idx_q == LOG2N'(N - 1)) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Sample/bin memory; never cleared, and nothing is written in a reset cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wrLoad) begin
                memRe_q[bitRev(cnt_q)] <= OW'(in_re);
                memIm_q[bitRev(cnt_q)] <= OW'(in_im);
            end
            if (wrBfly) begin
                memRe_q[aAddr] <= sumRe;
                memIm_q[aAddr] <= sumIm;
                memRe_q[bAddr] <= difRe;
                memIm_q[bAddr] <= difIm;
            end
        end
    end

    assign out_idx = idx_q;
    assign out_re  = out_valid ? memRe_q[idx_q] : '0;
    assign out_im  = out_valid ? memIm_q[idx_q] : '0;

endmodule
